// File: rtl/picorv32_pcpi_initiator_if.sv
// Command, PCPI and response channels of the PCPI initiator.
// master: the initiator. slave: the environment, i.e. the command source,
// the PCPI responder and the response consumer.
interface picorv32_pcpi_initiator_if #(
    parameter int unsigned LAT_W = 16
);
    // Command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_insn;
    logic [31:0]      cmd_rs1;
    logic [31:0]      cmd_rs2;
    // PCPI channel
    logic             pcpi_valid;
    logic [31:0]      pcpi_insn;
    logic [31:0]      pcpi_rs1;
    logic [31:0]      pcpi_rs2;
    logic             pcpi_wr;
    logic [31:0]      pcpi_rd;
    logic             pcpi_wait;
    logic             pcpi_ready;
    // Response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_rd;
    logic             rsp_wr;
    logic             rsp_err;
    logic [LAT_W-1:0] rsp_cycles;

    modport master (
        input  cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  rsp_ready,
        output cmd_ready,
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output rsp_valid, rsp_rd, rsp_wr, rsp_err, rsp_cycles
    );

    modport slave (
        output cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output rsp_ready,
        input  cmd_ready,
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  rsp_valid, rsp_rd, rsp_wr, rsp_err, rsp_cycles
    );
endinterface

// File: rtl/picorv32_pcpi_initiator.sv
// PCPI initiator: takes one command, issues it as a PCPI request, waits for the
// responder (or times out if nobody claims it) and holds the result until it is
// consumed. All outputs come straight from flops.
module picorv32_pcpi_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned LAT_W          = 16
) (
    input logic                         clk,
    input logic                         resetn,
    picorv32_pcpi_initiator_if.master   bus
);
    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    // Last unclaimed cycle before giving up
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             pcpi_valid_q, pcpi_valid_d;
    logic [31:0]      pcpi_insn_q, pcpi_insn_d;
    logic [31:0]      pcpi_rs1_q, pcpi_rs1_d;
    logic [31:0]      pcpi_rs2_q, pcpi_rs2_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rd_q, rsp_rd_d;
    logic             rsp_wr_q, rsp_wr_d;
    logic             rsp_err_q, rsp_err_d;
    logic [LAT_W-1:0] cycles_q, cycles_d;
    logic [7:0]       tmo_q, tmo_d;

    // Next-state and next-output logic; every register holds by default
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        pcpi_valid_d = pcpi_valid_q;
        pcpi_insn_d  = pcpi_insn_q;
        pcpi_rs1_d   = pcpi_rs1_q;
        pcpi_rs2_d   = pcpi_rs2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rd_d     = rsp_rd_q;
        rsp_wr_d     = rsp_wr_q;
        rsp_err_d    = rsp_err_q;
        cycles_d     = cycles_q;
        tmo_d        = tmo_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    pcpi_insn_d  = bus.cmd_insn;
                    pcpi_rs1_d   = bus.cmd_rs1;
                    pcpi_rs2_d   = bus.cmd_rs2;
                    pcpi_valid_d = 1'b1;
                    cmd_ready_d  = 1'b0;
                    cycles_d     = '0;
                    tmo_d        = '0;
                    state_d      = StReq;
                end
            end
            StReq: begin
                // Latency counts every request cycle, including the exit cycle
                if (cycles_q != {LAT_W{1'b1}}) begin
                    cycles_d = cycles_q + LAT_W'(1);
                end
                tmo_d = bus.pcpi_wait ? 8'd0 : tmo_q + 8'd1;
                // Completion beats a simultaneous timeout
                if (bus.pcpi_ready) begin
                    rsp_rd_d     = bus.pcpi_rd;
                    rsp_wr_d     = bus.pcpi_wr;
                    rsp_err_d    = 1'b0;
                    pcpi_valid_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = StResp;
                end else if (!bus.pcpi_wait && tmo_q == TmoLast) begin
                    rsp_rd_d     = '0;
                    rsp_wr_d     = 1'b0;
                    rsp_err_d    = 1'b1;
                    pcpi_valid_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp: begin
                // Always pass through IDLE so requests are separated by two idle cycles
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            cmd_ready_q  <= 1'b1;
            pcpi_valid_q <= 1'b0;
            pcpi_insn_q  <= '0;
            pcpi_rs1_q   <= '0;
            pcpi_rs2_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rd_q     <= '0;
            rsp_wr_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            cycles_q     <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            pcpi_valid_q <= pcpi_valid_d;
            pcpi_insn_q  <= pcpi_insn_d;
            pcpi_rs1_q   <= pcpi_rs1_d;
            pcpi_rs2_q   <= pcpi_rs2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_wr_q     <= rsp_wr_d;
            rsp_err_q    <= rsp_err_d;
            cycles_q     <= cycles_d;
            tmo_q        <= tmo_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.pcpi_valid = pcpi_valid_q;
    assign bus.pcpi_insn  = pcpi_insn_q;
    assign bus.pcpi_rs1   = pcpi_rs1_q;
    assign bus.pcpi_rs2   = pcpi_rs2_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rd     = rsp_rd_q;
    assign bus.rsp_wr     = rsp_wr_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_cycles = cycles_q;
endmodule

// File: doc/picorv32_pcpi_initiator.md
PICORV32_PCPI_INITIATOR -- requirements
Module: picorv32_pcpi_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, sets the number of consecutive REQ cycles with pcpi_wait low that trigger a timeout; legal range 2..255.
REQ-002 Parameter LAT_W, default 16, sets the width of rsp_cycles.
REQ-003 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 Port resetn, input, 1 bit: asynchronous active-low reset.
REQ-005 Port cmd_valid, input, 1 bit: a command is offered.
REQ-006 Port cmd_ready, output, 1 bit: a command is accepted this cycle.
REQ-007 Port cmd_insn, input, 32 bits: instruction word to issue.
REQ-008 Port cmd_rs1, input, 32 bits: operand 1.
REQ-009 Port cmd_rs2, input, 32 bits: operand 2.
REQ-010 Port pcpi_valid, output, 1 bit: a PCPI request is active.
REQ-011 Port pcpi_insn, output, 32 bits: PCPI instruction.
REQ-012 Port pcpi_rs1, output, 32 bits: PCPI operand 1.
REQ-013 Port pcpi_rs2, output, 32 bits: PCPI operand 2.
REQ-014 Port pcpi_wr, input, 1 bit: the responder writes pcpi_rd.
REQ-015 Port pcpi_rd, input, 32 bits: responder result.
REQ-016 Port pcpi_wait, input, 1 bit: the responder has claimed the instruction and is busy.
REQ-017 Port pcpi_ready, input, 1 bit: the responder has completed.
REQ-018 Port rsp_valid, output, 1 bit: a response is held.
REQ-019 Port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-020 Port rsp_rd, output, 32 bits: result data.
REQ-021 Port rsp_wr, output, 1 bit: result is to be written.
REQ-022 Port rsp_err, output, 1 bit: the request timed out with no claim.
REQ-023 Port rsp_cycles, output, LAT_W bits: number of cycles pcpi_valid was high.

Function
REQ-024 The block SHALL implement the FSM IDLE -> REQ -> RESP -> IDLE, and all outputs SHALL be registered.
REQ-025 In IDLE, cmd_ready SHALL be 1; in REQ and RESP, cmd_ready SHALL be 0.
REQ-026 A handshake (cmd_valid && cmd_ready) SHALL latch insn/rs1/rs2 into pcpi_insn/pcpi_rs1/pcpi_rs2, set pcpi_valid=1 on the next cycle, clear the timeout and latency counters, and move to REQ.
REQ-027 In REQ, pcpi_valid and the pcpi_insn/pcpi_rs1/pcpi_rs2 outputs SHALL be held stable until exit from REQ.
REQ-028 Each REQ cycle SHALL increment rsp_cycles, saturating at all-ones.
REQ-029 In a REQ cycle with pcpi_wait=0 the timeout counter SHALL increment; any cycle with pcpi_wait=1 SHALL clear it to 0.
REQ-030 When pcpi_ready=1 in REQ, at that edge: rsp_rd<=pcpi_rd, rsp_wr<=pcpi_wr, rsp_err<=0, pcpi_valid<=0, rsp_valid<=1, and the FSM SHALL move to RESP.
REQ-031 When the timeout counter reaches TIMEOUT_CYCLES-1 with pcpi_wait=0 and pcpi_ready=0, at that edge: rsp_err<=1, rsp_wr<=0, rsp_rd<=0, pcpi_valid<=0, rsp_valid<=1, and the FSM SHALL move to RESP.
REQ-032 If pcpi_ready and timeout occur in the same cycle, pcpi_ready SHALL win and rsp_err SHALL be 0.
REQ-033 pcpi_ready asserted on the first REQ cycle SHALL be honoured, giving rsp_cycles=1.
REQ-034 pcpi_ready, pcpi_wr, pcpi_rd and pcpi_wait SHALL be ignored outside REQ.
REQ-035 In RESP, rsp_valid and all rsp_* outputs SHALL be held until rsp_valid && rsp_ready; at that edge rsp_valid<=0 and the FSM SHALL move to IDLE.
REQ-036 The FSM SHALL never go from RESP directly to REQ; pcpi_valid SHALL therefore be low for at least 2 cycles between requests.
REQ-037 Minimum issue-to-response latency SHALL be: handshake at edge k, pcpi_valid high in cycle k+1, pcpi_ready at edge k+1, rsp_valid high in cycle k+2.

Reset
REQ-038 resetn=0 SHALL immediately force the FSM to IDLE and clear both counters.
REQ-039 During and after reset, outputs SHALL be: pcpi_valid=0, rsp_valid=0, rsp_wr=0, rsp_err=0, cmd_ready=1, and all data outputs 0.
REQ-040 Reset asserted in REQ or RESP SHALL discard the transaction with no response; the first post-reset cmd SHALL be accepted normally.

Verification
REQ-041 Scenario MUL: insn=0x02B50533 (MUL) with a MUL responder, rs1=3, rs2=5 -> one response with rsp_rd=15, rsp_wr=1, rsp_err=0, rsp_cycles equal to the count of pcpi_valid-high cycles.
REQ-042 Scenario MULHU: rs1=rs2=0xFFFFFFFF (funct3=011) -> rsp_rd=0xFFFFFFFE; MULH with rs1=rs2=0xFFFFFFFF -> rsp_rd=0.
REQ-043 Scenario timeout: no responder (wait=0, ready=0) -> pcpi_valid high for exactly 16 cycles, then rsp_err=1, rsp_wr=0, rsp_rd=0, rsp_cycles=16.
REQ-044 Scenario long wait: responder holds pcpi_wait=1 for 100 cycles, then ready with rd=0xA5A5A5A5 -> no timeout, rsp_rd=0xA5A5A5A5, rsp_err=0.
REQ-045 Scenario backpressure and collision: rsp_ready=0 for 10 cycles -> rsp_* stable and cmd_ready=0 throughout; pcpi_ready coinciding with the timeout cycle -> rsp_err=0.
REQ-046 Scenario reset mid-REQ: resetn low 3 cycles -> pcpi_valid=0 immediately and no rsp_valid; the next MUL 7*6 -> rsp_rd=42.
